qarctan_arbiter: RTL and testbench
==================================

QARCTAN_ARBITER -- requirements
Module: qarctan_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_SIZE, default 32, operand/result width; NUM_REQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 Reset SHALL be `reset`, asynchronous, active-high; clock SHALL be `clock`.
REQ-003 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- in_valid  in  NUM_REQ  per-requester operand valid
- in_ready  out  NUM_REQ  per-requester operand accept
- in_real  in  NUM_REQ x DATA_SIZE  signed real operand per requester
- in_imag  in  NUM_REQ x DATA_SIZE  signed imag operand per requester
- out_valid  out  NUM_REQ  per-requester result valid
- out_ready  in  NUM_REQ  per-requester result accept
- out_data  out  DATA_SIZE  signed angle, shared bus, qualified by out_valid
- busy  out  1  high whenever state is not IDLE

Function
REQ-004 The block SHALL share one qarctan core among NUM_REQ requesters, one transaction in flight at a time.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT, DELIVER.
REQ-006 IDLE: if any in_valid is high, grant one requester, assert in_ready for that requester only (combinationally, same cycle), latch its in_real/in_imag and grant index, then go to ISSUE; otherwise stay.
REQ-007 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester other than last_grant; last_grant resets to 1, so requester 0 wins the first contention.
REQ-008 ISSUE: pulse core start_signal for exactly one cycle, then go to WAIT.
REQ-009 Latched operands SHALL drive core real_/imag unchanged from ISSUE through WAIT, because the core samples them in both its first and angle phases.
REQ-010 WAIT: on core done_signal, register core data_out into result_reg and go to DELIVER.
REQ-011 DELIVER: assert out_valid[grant] with out_data = result_reg; hold both stable until out_ready[grant] is high.
REQ-012 The out_valid/out_ready handshake SHALL complete in the same cycle as the return to IDLE; last_grant SHALL update to grant on that cycle.
REQ-013 At most one out_valid bit and at most one in_ready bit SHALL be high in any cycle.
REQ-014 No operand SHALL be accepted outside IDLE; in_ready SHALL be 0 in ISSUE, WAIT and DELIVER.
REQ-015 Latency from the accept cycle to first out_valid SHALL be 2 + core latency (ISSUE + core cycles + capture).
REQ-016 out_ready on a non-granted requester SHALL be ignored; out_ready asserted before DELIVER SHALL have no effect.
REQ-017 out_data SHALL be 0 whenever no out_valid bit is high.

Reset
REQ-018 Reset SHALL force state IDLE, last_grant=1, result_reg=0, latched operands=0, and all outputs to 0; it SHALL also reset the qarctan core.
REQ-019 Reset asserted mid-transaction SHALL abort it with no result delivered; after deassertion, the first accepted request SHALL start cleanly.

Structure
REQ-020 The state enum type and the DATA_SIZE/NUM_REQ defaults SHALL live in the shared radio package; the QUAD_ONE/QUAD_THREE constants stay with qarctan.
REQ-021 Exactly one sub-module instance SHALL be used: qarctan (which itself contains the divider).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Req0 only, real=1024, imag=0 -> in_ready[0] pulses once; out_valid[0] with out_data=0x00000000; busy falls after the handshake.
- Req1 only, real=0, imag=0 -> out_valid[1] with out_data=0x00000648.
- Both valid in the same cycle, twice in a row -> grants in order 0, 1, 0, 1; each result returns on the matching out_valid bit.
- out_ready[0] held low for 10 cycles in DELIVER -> out_valid[0] and out_data stay stable; no new in_ready during the stall; completes when out_ready rises.
- in_real/in_imag toggled during WAIT -> result still matches the latched operands.
- Reset pulsed during WAIT -> no out_valid appears; the next request (1024, 0) returns 0.

Source files
------------

// File: rtl/qarctan_arbiter_pkg.sv
// qarctan_arbiter_pkg: shared radio types and defaults for the arbitrated arctan core.
package qarctan_arbiter_pkg;
  localparam int DATA_SIZE_DEF = 32;
  localparam int NUM_REQ_DEF = 2;
  localparam int ANGLE_FRAC = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} arb_state_t;
  typedef enum logic [1:0] {C_IDLE, C_DIV, C_ANGLE} core_state_t;
endpackage

// File: rtl/qarctan_arbiter_qarctan.sv
// qarctan: quadrant arctan approximation in Q10 radians with an iterative restoring divider.
module qarctan
  import qarctan_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_signal,
  input  logic signed [DATA_SIZE-1:0] real_,
  input  logic signed [DATA_SIZE-1:0] imag,
  output logic                        done_signal,
  output logic signed [DATA_SIZE-1:0] data_out
);
  localparam logic signed [DATA_SIZE-1:0] QUAD_ONE = 804;
  localparam logic signed [DATA_SIZE-1:0] QUAD_THREE = 2412;
  localparam int CW = $clog2(DATA_SIZE + 1);
  core_state_t state, state_nx;
  logic [DATA_SIZE-1:0] rem, quo, den, mag;
  logic [DATA_SIZE:0] rem_sh, rem_sub;
  logic [CW-1:0] cnt;
  logic neg;
  logic signed [DATA_SIZE-1:0] abs_y, num, den_c, q, angle;
  logic signed [DATA_SIZE+ANGLE_FRAC-1:0] prod;
  // A zero vector is nudged to (0,1) so the divisor is never zero.
  always_comb begin
    abs_y = (real_ == '0 && imag == '0) ? DATA_SIZE'(1) : (imag[DATA_SIZE-1] ? -imag : imag);
    num = real_[DATA_SIZE-1] ? real_ + abs_y : real_ - abs_y;
    den_c = real_[DATA_SIZE-1] ? abs_y - real_ : real_ + abs_y;
    mag = num[DATA_SIZE-1] ? -num : num;
    rem_sh = {rem, quo[DATA_SIZE-1]};
    rem_sub = rem_sh - {1'b0, den};
    q = neg ? -$signed(quo) : $signed(quo);
    prod = q * QUAD_ONE;
    angle = (real_[DATA_SIZE-1] ? QUAD_THREE : QUAD_ONE) - DATA_SIZE'(prod >>> ANGLE_FRAC);
    state_nx = state == C_IDLE ? (start_signal ? C_DIV : C_IDLE) :
               state == C_DIV ? (cnt == CW'(DATA_SIZE - 1) ? C_ANGLE : C_DIV) : C_IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= C_IDLE;
      rem <= '0;
      quo <= '0;
      den <= '0;
      neg <= 1'b0;
      cnt <= '0;
      done_signal <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nx;
      done_signal <= state == C_ANGLE;
      if (state == C_IDLE && start_signal) begin
        rem <= '0;
        quo <= mag << ANGLE_FRAC;
        den <= den_c;
        neg <= num[DATA_SIZE-1];
        cnt <= '0;
      end
      if (state == C_DIV) begin
        rem <= rem_sub[DATA_SIZE] ? rem_sh[DATA_SIZE-1:0] : rem_sub[DATA_SIZE-1:0];
        quo <= {quo[DATA_SIZE-2:0], ~rem_sub[DATA_SIZE]};
        cnt <= cnt + 1'b1;
      end
      if (state == C_ANGLE) data_out <= imag[DATA_SIZE-1] ? -angle : angle;
    end
endmodule

// File: rtl/qarctan_arbiter.sv
// qarctan_arbiter: round-robin sharing of one qarctan core between two requesters.
module qarctan_arbiter
  import qarctan_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 in_valid,
  output logic [NUM_REQ-1:0]                 in_ready,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  in_real,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]  in_imag,
  output logic [NUM_REQ-1:0]                 out_valid,
  input  logic [NUM_REQ-1:0]                 out_ready,
  output logic [DATA_SIZE-1:0]               out_data,
  output logic                               busy
);
  arb_state_t state, state_nx;
  logic last_grant, grant, pick, done;
  logic [DATA_SIZE-1:0] op_real, op_imag, result_reg, core_data;
  always_comb begin
    pick = &in_valid ? ~last_grant : in_valid[1];
    in_ready = (state == IDLE && |in_valid && !reset) ? NUM_REQ'(1) << pick : '0;
    out_valid = state == DELIVER ? NUM_REQ'(1) << grant : '0;
    out_data = state == DELIVER ? result_reg : '0;
    busy = state != IDLE;
    state_nx = state == IDLE ? (|in_valid ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT ? (done ? DELIVER : WAIT) :
               (out_ready[grant] ? IDLE : DELIVER);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      op_real <= '0;
      op_imag <= '0;
      result_reg <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |in_valid) begin
        grant <= pick;
        op_real <= in_real[pick];
        op_imag <= in_imag[pick];
      end
      if (state == WAIT && done) result_reg <= core_data;
      if (state == DELIVER && out_ready[grant]) last_grant <= grant;
    end
  // Operands stay latched until the next accept, so the core may resample them.
  qarctan #(.DATA_SIZE(DATA_SIZE)) u_core (
    .clock(clock),
    .reset(reset),
    .start_signal(state == ISSUE),
    .real_(op_real),
    .imag(op_imag),
    .done_signal(done),
    .data_out(core_data)
  );
endmodule

// File: tb/tb_qarctan_arbiter.sv
// tb_qarctan_arbiter: randomized and directed checks of the arbiter against an arithmetic arctan model.
module tb_qarctan_arbiter;
  typedef struct {int re; int im; logic [31:0] want;} op_t;
  typedef struct {int req; logic [31:0] data;} exp_t;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] in_valid = '0, in_ready, out_valid, out_ready = '0;
  logic [1:0][31:0] in_real = '0, in_imag = '0;
  logic [31:0] out_data;
  logic busy;
  int total = 0, bad = 0, dcyc = 0, stall_len = 0;
  bit m_last = 1'b1, m_busy = 1'b0;
  op_t pend[2][$];
  exp_t sb[$];
  int grants[$];
  qarctan_arbiter #(.DATA_SIZE(32), .NUM_REQ(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  // Angle in Q10 radians: pi/4 * (1 - r) style quadrant approximation.
  function automatic logic [31:0] ref_angle(int re, int im);
    longint x = re, y = (im < 0) ? -longint'(im) : longint'(im), r, a;
    if (re == 0 && im == 0) y = 1;
    r = (x >= 0) ? ((x - y) * 1024) / (x + y) : ((x + y) * 1024) / (y - x);
    a = (x >= 0 ? 804 : 2412) - ((804 * r) >>> 10);
    return 32'(im < 0 ? -a : a);
  endfunction
  function automatic op_t rnd_op();
    int re = int'($urandom_range(0, 60000)) - 30000;
    int im = int'($urandom_range(0, 60000)) - 30000;
    return '{re, im, ref_angle(re, im)};
  endfunction
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = pend[i].size() != 0;
      in_real[i] = in_valid[i] ? pend[i][0].re : $urandom;
      in_imag[i] = in_valid[i] ? pend[i][0].im : $urandom;
    end
    dcyc = out_valid != 0 ? dcyc + 1 : 0;
    out_ready = 2'($urandom);
    if (out_valid != 0 && sb.size() != 0) out_ready[sb[0].req] = dcyc > stall_len;
  endtask
  task automatic step();
    logic [1:0] exp_rdy, acc, fire;
    @(negedge clock);
    exp_rdy = (!m_busy && in_valid != 0) ? (in_valid == 2'b11 ? (m_last ? 2'b01 : 2'b10) : in_valid) : 2'b00;
    check("in_ready", in_ready, exp_rdy);
    check("busy", busy, m_busy);
    if (out_valid == 0) check("idle_data", out_data, 0);
    else if (sb.size() == 0) check("spurious_valid", out_valid, 0);
    else begin
      check("out_valid", out_valid, 2'b01 << sb[0].req);
      check("out_data", out_data, sb[0].data);
    end
    acc = in_ready & in_valid;
    fire = out_valid & out_ready;
    if (fire != 0) check("deliver_len", dcyc, stall_len + 1);
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++)
      if (acc[i] && pend[i].size() != 0) begin
        sb.push_back('{i, pend[i][0].want});
        void'(pend[i].pop_front());
        grants.push_back(i);
        m_busy = 1'b1;
      end
    if (fire != 0 && sb.size() != 0) begin
      m_last = sb[0].req[0];
      void'(sb.pop_front());
      m_busy = 1'b0;
    end
    drive();
  endtask
  task automatic run(int limit);
    int n = 0;
    drive();
    while (pend[0].size() + pend[1].size() + sb.size() != 0 && n < limit) begin
      step();
      n++;
    end
    check("drain", pend[0].size() + pend[1].size() + sb.size(), 0);
  endtask
  initial begin
    in_valid = 2'b11;
    @(negedge clock);
    check("reset_outs", {in_ready, out_valid, busy, out_data}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive();
    repeat (3) step();
    pend[0].push_back('{1024, 0, 32'h0});
    run(200);
    check("req0_pulses", grants.size(), 1);
    check("req0_grant", grants[0], 0);
    pend[1].push_back('{0, 0, 32'h648});
    run(200);
    grants.delete();
    for (int k = 0; k < 2; k++) begin
      pend[0].push_back(rnd_op());
      pend[1].push_back(rnd_op());
    end
    run(400);
    check("contention_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) check("grant_order", grants[k], k % 2);
    stall_len = 10;
    pend[0].push_back('{-700, 300, ref_angle(-700, 300)});
    run(200);
    stall_len = 0;
    pend[1].push_back('{-5000, -20000, ref_angle(-5000, -20000)});
    run(200);
    pend[0].push_back('{3000, -500, ref_angle(3000, -500)});
    drive();
    repeat (8) step();
    check("in_wait", busy, 1);
    #2 reset = 1'b1;
    #1 check("async_reset", busy, 0);
    sb.delete();
    pend[0].delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    in_valid = 2'b11;
    @(negedge clock);
    check("reset_mid_outs", {in_ready, out_valid, busy, out_data}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    drive();
    repeat (50) step();
    pend[0].push_back('{1024, 0, 32'h0});
    run(200);
    for (int t = 0; t < 40; t++) begin
      int who = int'($urandom_range(1, 3));
      stall_len = int'($urandom_range(0, 3));
      if (who[0]) pend[0].push_back(rnd_op());
      if (who[1]) pend[1].push_back(rnd_op());
      run(400);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
